// File: rtl/tpm_port_scheduler.sv
// tpm_port_scheduler: time-multiplexes one single-port SRAM among three
// request ports. Grants rotate so the last-served port drops to lowest
// priority. Read data is routed back through a {valid, port_id} tag pipeline.
// Optional grant/stall statistics are enabled with `define TPM_SCHED_STATS_EN.
module tpm_port_scheduler #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p1_req_i,
    input  logic          p2_req_i,
    input  logic          p3_req_i,
    input  logic          p1_we_i,
    input  logic          p2_we_i,
    input  logic          p3_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [AW-1:0] p2_addr_i,
    input  logic [AW-1:0] p3_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    input  logic [DW-1:0] p2_wdata_i,
    input  logic [DW-1:0] p3_wdata_i,
    output logic          p1_gnt_o,
    output logic          p2_gnt_o,
    output logic          p3_gnt_o,
    output logic          p1_rvalid_o,
    output logic          p2_rvalid_o,
    output logic          p3_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic [DW-1:0] p2_rdata_o,
    output logic [DW-1:0] p3_rdata_o,
    input  logic          mem_stall_i,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
`ifdef TPM_SCHED_STATS_EN
    ,
    input  logic          stat_clr_i,
    output logic [15:0]   stat_p1_cnt_o,
    output logic [15:0]   stat_p2_cnt_o,
    output logic [15:0]   stat_p3_cnt_o,
    output logic [15:0]   stat_stall_cnt_o
`endif
);

    // Port ids are 1..3; 0 means "no port".
    logic [1:0]    ord0_q, ord1_q, ord2_q;
    logic [1:0]    ord0_d, ord1_d, ord2_d;
    logic [1:0]    gnt_id;
    logic          gnt_any;
    logic [2:0]    req_v;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [2:0]    tag_q [MEM_LAT+1];
    logic [2:0]    ret_tag;
    logic          p1_rvalid_q, p2_rvalid_q, p3_rvalid_q;
    logic [DW-1:0] p1_rdata_q, p2_rdata_q, p3_rdata_q;

    function automatic logic req_of(input logic [1:0] id, input logic [2:0] r);
        case (id)
            2'd1:    req_of = r[0];
            2'd2:    req_of = r[1];
            2'd3:    req_of = r[2];
            default: req_of = 1'b0;
        endcase
    endfunction

    assign req_v = {p3_req_i, p2_req_i, p1_req_i};

    // Pick the highest-priority pending port unless the SRAM is stalled.
    always_comb begin
        gnt_id = 2'd0;
        if (!mem_stall_i) begin
            if (req_of(ord0_q, req_v))      gnt_id = ord0_q;
            else if (req_of(ord1_q, req_v)) gnt_id = ord1_q;
            else if (req_of(ord2_q, req_v)) gnt_id = ord2_q;
        end
    end

    assign gnt_any  = (gnt_id != 2'd0);
    assign p1_gnt_o = (gnt_id == 2'd1);
    assign p2_gnt_o = (gnt_id == 2'd2);
    assign p3_gnt_o = (gnt_id == 2'd3);

    // Select the granted port's command and compute the rotated order.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (gnt_id)
            2'd1: begin sel_we = p1_we_i; sel_addr = p1_addr_i; sel_wdata = p1_wdata_i; end
            2'd2: begin sel_we = p2_we_i; sel_addr = p2_addr_i; sel_wdata = p2_wdata_i; end
            2'd3: begin sel_we = p3_we_i; sel_addr = p3_addr_i; sel_wdata = p3_wdata_i; end
            default: ;
        endcase
        ord0_d = ord0_q;
        ord1_d = ord1_q;
        ord2_d = ord2_q;
        if (gnt_any) begin
            if (gnt_id == ord0_q) begin
                ord0_d = ord1_q; ord1_d = ord2_q; ord2_d = ord0_q;
            end else if (gnt_id == ord1_q) begin
                ord1_d = ord2_q; ord2_d = ord1_q;
            end
        end
    end

    // Priority order register; the served port moves to the back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ord0_q <= 2'd1;
            ord1_q <= 2'd2;
            ord2_q <= 2'd3;
        end else begin
            ord0_q <= ord0_d;
            ord1_q <= ord1_d;
            ord2_q <= ord2_d;
        end
    end

    // Registered SRAM command; address/data hold when nothing is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= gnt_any;
            mem_we_q <= gnt_any & sel_we;
            if (gnt_any) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
        end
    end

    // Tag pipeline: stage k is visible k+1 cycles after the grant, so the
    // last stage lines up with mem_rdata for that read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= MEM_LAT; i++) tag_q[i] <= 3'd0;
        end else begin
            tag_q[0] <= {gnt_any & ~sel_we, gnt_id};
            for (int i = 1; i <= MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign ret_tag = tag_q[MEM_LAT];

    // Capture returning read data into the originating port's registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_rvalid_q <= 1'b0;
            p2_rvalid_q <= 1'b0;
            p3_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p2_rdata_q  <= '0;
            p3_rdata_q  <= '0;
        end else begin
            p1_rvalid_q <= ret_tag[2] && (ret_tag[1:0] == 2'd1);
            p2_rvalid_q <= ret_tag[2] && (ret_tag[1:0] == 2'd2);
            p3_rvalid_q <= ret_tag[2] && (ret_tag[1:0] == 2'd3);
            if (ret_tag[2] && (ret_tag[1:0] == 2'd1)) p1_rdata_q <= mem_rdata_i;
            if (ret_tag[2] && (ret_tag[1:0] == 2'd2)) p2_rdata_q <= mem_rdata_i;
            if (ret_tag[2] && (ret_tag[1:0] == 2'd3)) p3_rdata_q <= mem_rdata_i;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p2_rvalid_o = p2_rvalid_q;
    assign p3_rvalid_o = p3_rvalid_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign p2_rdata_o  = p2_rdata_q;
    assign p3_rdata_o  = p3_rdata_q;

`ifdef TPM_SCHED_STATS_EN
    // The scheduler state is only observable through the stall counter, so
    // the FSM lives with the statistics.
    typedef enum logic [1:0] {IDLE, ISSUE, STALLED} state_t;
    state_t        state_q;
    logic [15:0]   p1_cnt_q, p2_cnt_q, p3_cnt_q, stall_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scheduler FSM: IDLE with no request, STALLED when blocked, else ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (req_v == 3'b000) begin
            state_q <= IDLE;
        end else if (mem_stall_i) begin
            state_q <= STALLED;
        end else begin
            state_q <= ISSUE;
        end
    end

    // Saturating grant and stall counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_cnt_q    <= '0;
            p2_cnt_q    <= '0;
            p3_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else if (stat_clr_i) begin
            p1_cnt_q    <= '0;
            p2_cnt_q    <= '0;
            p3_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (p1_gnt_o)            p1_cnt_q    <= sat_inc(p1_cnt_q);
            if (p2_gnt_o)            p2_cnt_q    <= sat_inc(p2_cnt_q);
            if (p3_gnt_o)            p3_cnt_q    <= sat_inc(p3_cnt_q);
            if (state_q == STALLED)  stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stat_p1_cnt_o    = p1_cnt_q;
    assign stat_p2_cnt_o    = p2_cnt_q;
    assign stat_p3_cnt_o    = p3_cnt_q;
    assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tpm_port_scheduler.sv
// Directed testbench for tpm_port_scheduler (MEM_LAT=1) with a simple
// one-cycle-latency SRAM model whose read data is 0xD0000000 | addr.
module tb_tpm_port_scheduler;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          p1_req = 0, p2_req = 0, p3_req = 0;
    logic          p1_we = 0, p2_we = 0, p3_we = 0;
    logic [AW-1:0] p1_addr = 0, p2_addr = 0, p3_addr = 0;
    logic [DW-1:0] p1_wdata = 0, p2_wdata = 0, p3_wdata = 0;
    logic          p1_gnt, p2_gnt, p3_gnt;
    logic          p1_rvalid, p2_rvalid, p3_rvalid;
    logic [DW-1:0] p1_rdata, p2_rdata, p3_rdata;
    logic          mem_stall = 0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 0;
`ifdef TPM_SCHED_STATS_EN
    logic          stat_clr = 0;
    logic [15:0]   stat_p1_cnt, stat_p2_cnt, stat_p3_cnt, stat_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    wire [2:0] gnt = {p3_gnt, p2_gnt, p1_gnt};
    wire [2:0] rv  = {p3_rvalid, p2_rvalid, p1_rvalid};

    tpm_port_scheduler #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .p1_req_i(p1_req), .p2_req_i(p2_req), .p3_req_i(p3_req),
        .p1_we_i(p1_we), .p2_we_i(p2_we), .p3_we_i(p3_we),
        .p1_addr_i(p1_addr), .p2_addr_i(p2_addr), .p3_addr_i(p3_addr),
        .p1_wdata_i(p1_wdata), .p2_wdata_i(p2_wdata), .p3_wdata_i(p3_wdata),
        .p1_gnt_o(p1_gnt), .p2_gnt_o(p2_gnt), .p3_gnt_o(p3_gnt),
        .p1_rvalid_o(p1_rvalid), .p2_rvalid_o(p2_rvalid), .p3_rvalid_o(p3_rvalid),
        .p1_rdata_o(p1_rdata), .p2_rdata_o(p2_rdata), .p3_rdata_o(p3_rdata),
        .mem_stall_i(mem_stall), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef TPM_SCHED_STATS_EN
        , .stat_clr_i(stat_clr), .stat_p1_cnt_o(stat_p1_cnt), .stat_p2_cnt_o(stat_p2_cnt),
        .stat_p3_cnt_o(stat_p3_cnt), .stat_stall_cnt_o(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model with one cycle of read latency
    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= 32'hD000_0000 | {22'd0, mem_addr};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p1_req = 0; p2_req = 0; p3_req = 0;
        p1_we = 0; p2_we = 0; p3_we = 0;
        p1_addr = 0; p2_addr = 0; p3_addr = 0;
        p1_wdata = 0; p2_wdata = 0; p3_wdata = 0;
        mem_stall = 0;
`ifdef TPM_SCHED_STATS_EN
        stat_clr = 0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({gnt, rv, mem_en, mem_we} !== 8'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000000", {gnt, rv, mem_en, mem_we});
        end
        tests++;
        if ({mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_mem: addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        tests++;
        if ({p1_rdata, p2_rdata, p3_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_rdata: %h %h %h want 0", p1_rdata, p2_rdata, p3_rdata);
        end
        reset_n = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        cyc();
        p2_req = 1; p2_we = 0; p2_addr = 10'h005;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b010) begin
            fails++; $display("FAIL single_gnt: got %b want 010", gnt);
        end
        cyc();
        p2_req = 0;
        @(negedge clk);
        tests++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h005}) begin
            fails++; $display("FAIL single_issue: en %b we %b addr %h want 1 0 005", mem_en, mem_we, mem_addr);
        end
        cyc();
        @(negedge clk);
        tests++;
        if ({rv, mem_en} !== 4'b0000) begin
            fails++; $display("FAIL single_early: rv %b en %b want 000 0", rv, mem_en);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (rv !== 3'b010 || p2_rdata !== 32'hD000_0005) begin
            fails++; $display("FAIL single_return: rv %b data %h want 010 d0000005", rv, p2_rdata);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (rv !== 3'b000) begin
            fails++; $display("FAIL single_after: rv %b want 000", rv);
        end
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_g;
        logic [31:0] exp_d;
        logic [31:0] got_d;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c == 0) begin
                p1_req = 1; p1_addr = 10'h001;
                p2_req = 1; p2_addr = 10'h002;
                p3_req = 1; p3_addr = 10'h003;
            end else if (c == 6) begin
                p1_req = 0; p2_req = 0; p3_req = 0;
            end
            @(negedge clk);
            if (c < 6) begin
                exp_g = 3'b001 << (c % 3);
                tests++;
                if (gnt !== exp_g) begin
                    fails++; $display("FAIL fair_gnt c%0d: got %b want %b", c, gnt, exp_g);
                end
            end
            if (c >= 3 && c <= 8) begin
                exp_g = 3'b001 << ((c - 3) % 3);
                exp_d = 32'hD000_0000 + ((c - 3) % 3) + 1;
                got_d = ((c - 3) % 3 == 0) ? p1_rdata : ((c - 3) % 3 == 1) ? p2_rdata : p3_rdata;
                tests++;
                if (rv !== exp_g || got_d !== exp_d) begin
                    fails++; $display("FAIL fair_ret c%0d: rv %b data %h want %b %h", c, rv, got_d, exp_g, exp_d);
                end
            end else begin
                tests++;
                if (rv !== 3'b000) begin
                    fails++; $display("FAIL fair_idle c%0d: rv %b want 000", c, rv);
                end
            end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        cyc();
        p3_req = 1; p3_addr = 10'h030;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b100) begin
            fails++; $display("FAIL rot_p3: got %b want 100", gnt);
        end
        cyc();
        p1_req = 1; p1_addr = 10'h010;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001) begin
            fails++; $display("FAIL rot_p1: got %b want 001", gnt);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (gnt !== 3'b100) begin
            fails++; $display("FAIL rot_p3b: got %b want 100", gnt);
        end
        cyc();
        p3_req = 0;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001) begin
            fails++; $display("FAIL rot_p1b: got %b want 001", gnt);
        end
        cyc();
        p1_req = 0;
    endtask

    task automatic test_write();
        do_reset();
        cyc();
        p3_req = 1; p3_we = 1; p3_addr = 10'h3FF; p3_wdata = 32'hCAFE_BABE;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b100) begin
            fails++; $display("FAIL wr_gnt: got %b want 100", gnt);
        end
        cyc();
        p3_req = 0; p3_we = 0; p3_addr = 0; p3_wdata = 0;
        @(negedge clk);
        tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h3FF, 32'hCAFE_BABE}) begin
            fails++; $display("FAIL wr_issue: en %b we %b addr %h wdata %h", mem_en, mem_we, mem_addr, mem_wdata);
        end
        cyc();
        @(negedge clk);
        tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 10'h3FF, 32'hCAFE_BABE}) begin
            fails++; $display("FAIL wr_hold: en %b we %b addr %h wdata %h", mem_en, mem_we, mem_addr, mem_wdata);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            @(negedge clk);
            tests++;
            if (rv !== 3'b000) begin
                fails++; $display("FAIL wr_no_rvalid c%0d: rv %b want 000", c, rv);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        p2_req = 1; p2_addr = 10'h007;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b010) begin
            fails++; $display("FAIL stall_pre_gnt: got %b want 010", gnt);
        end
        cyc();
        p2_req = 0; mem_stall = 1; p1_req = 1; p1_addr = 10'h009;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b000 || mem_en !== 1'b1 || mem_addr !== 10'h007) begin
            fails++; $display("FAIL stall_c1: gnt %b en %b addr %h want 000 1 007", gnt, mem_en, mem_addr);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (gnt !== 3'b000 || mem_en !== 1'b0) begin
            fails++; $display("FAIL stall_c2: gnt %b en %b want 000 0", gnt, mem_en);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (gnt !== 3'b000 || mem_en !== 1'b0 || rv !== 3'b010 || p2_rdata !== 32'hD000_0007) begin
            fails++; $display("FAIL stall_c3: gnt %b en %b rv %b data %h", gnt, mem_en, rv, p2_rdata);
        end
        cyc();
        mem_stall = 0;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001 || mem_en !== 1'b0) begin
            fails++; $display("FAIL stall_release: gnt %b en %b want 001 0", gnt, mem_en);
        end
        cyc();
        p1_req = 0;
        @(negedge clk);
        tests++;
        if (mem_en !== 1'b1 || mem_addr !== 10'h009) begin
            fails++; $display("FAIL stall_issue: en %b addr %h want 1 009", mem_en, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        p1_req = 1; p1_addr = 10'h004;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001) begin
            fails++; $display("FAIL rmid_gnt: got %b want 001", gnt);
        end
        cyc();
        p1_req = 0;
        @(negedge clk);
        tests++;
        if (mem_en !== 1'b1) begin
            fails++; $display("FAIL rmid_issue: en %b want 1", mem_en);
        end
        #1 reset_n = 0;
        #1;
        tests++;
        if ({rv, mem_en, mem_we, mem_addr, p1_rdata} !== '0) begin
            fails++; $display("FAIL rmid_zero: rv %b en %b addr %h rdata %h", rv, mem_en, mem_addr, p1_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge clk);
            tests++;
            if (rv !== 3'b000) begin
                fails++; $display("FAIL rmid_no_rvalid c%0d: rv %b want 000", c, rv);
            end
        end
        cyc();
        p1_req = 1; p2_req = 1; p3_req = 1;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001) begin
            fails++; $display("FAIL rmid_contest: got %b want 001", gnt);
        end
        cyc();
        p1_req = 0; p2_req = 0; p3_req = 0;
    endtask

`ifdef TPM_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        cyc();
        p1_req = 1; p1_addr = 10'h011;
        repeat (4) cyc();
        cyc();
        p1_req = 0;
        @(negedge clk);
        tests++;
        if (stat_p1_cnt !== 16'd5) begin
            fails++; $display("FAIL stat_p1: got %0d want 5", stat_p1_cnt);
        end
        cyc();
        p1_req = 1; stat_clr = 1;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b001) begin
            fails++; $display("FAIL stat_clr_gnt: got %b want 001", gnt);
        end
        cyc();
        p1_req = 0; stat_clr = 0;
        @(negedge clk);
        tests++;
        if (stat_p1_cnt !== 16'd0) begin
            fails++; $display("FAIL stat_clr: got %0d want 0", stat_p1_cnt);
        end
        cyc();
        p2_req = 1; mem_stall = 1;
        cyc();
        cyc();
        p2_req = 0; mem_stall = 0;
        cyc();
        @(negedge clk);
        tests++;
        if (stat_stall_cnt !== 16'd2 || stat_p2_cnt !== 16'd0) begin
            fails++; $display("FAIL stat_stall: stall %0d p2 %0d want 2 0", stat_stall_cnt, stat_p2_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_rotation();
        test_write();
        test_stall();
        test_reset_mid();
`ifdef TPM_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tpm_port_scheduler.md
Name: tpm_port_scheduler

Overview:
Shares one single-port SRAM macro among three request ports, providing triple-ported behaviour through time-multiplexing. Each cycle it grants at most one pending request using a rotating 3-way priority order, so the most recently served port drops to lowest priority. It issues the granted command to the SRAM and routes read data back to the originating port through a tag pipeline. It sits between the three port front-ends and the SRAM wrapper.

Parameters:
AW, 10, address width
DW, 32, data width
MEM_LAT, 1, SRAM read latency in cycles, mem_en to mem_rdata valid; legal range 1..4

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
p1_req/p2_req/p3_req  input  1 each  request pending; held until granted
p1_we/p2_we/p3_we  input  1 each  1=write, 0=read
p1_addr/p2_addr/p3_addr  input  AW each  request address
p1_wdata/p2_wdata/p3_wdata  input  DW each  write data
p1_gnt/p2_gnt/p3_gnt  output  1 each  combinational; request accepted this cycle
p1_rvalid/p2_rvalid/p3_rvalid  output  1 each  registered read-return pulse
p1_rdata/p2_rdata/p3_rdata  output  DW each  read data, valid with rvalid
mem_stall  input  1  SRAM busy; blocks new issue
mem_en, mem_we  output  1 each  registered SRAM command
mem_addr  output  AW  registered SRAM address
mem_wdata  output  DW  registered SRAM write data
mem_rdata  input  DW  SRAM read data

Behaviour:
- Reset: all gnt/rvalid/mem_en/mem_we = 0; mem_addr, mem_wdata, all rdata = 0; priority order = 1>2>3; FSM = IDLE; tag pipeline cleared.
- Reset is asynchronous. Reset mid-operation drops in-flight reads; no rvalid is produced for them after reset release.
- Grant: pK_gnt = pK_req & ~mem_stall & (K is the highest-priority requester). At most one gnt is high per cycle.
- Rotation: after a grant to port K, K moves to lowest priority and the other two keep their relative order. Examples: 123 with grant 1 gives 231; 231 with grant 3 gives 213. The order is unchanged on cycles with no grant.
- Issue: a grant in cycle T drives mem_en=1 with the port's we/addr/wdata in cycle T+1. In cycles with no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their previous values.
- Read return: for a read granted in cycle T, pK_rvalid=1 and pK_rdata=mem_rdata (registered) in cycle T+2+MEM_LAT. Tracking uses a shift register of depth MEM_LAT+1 holding {valid, port_id[1:0]}.
- Write return: writes produce no rvalid.
- Throughput: one request per cycle. Back-to-back reads from different ports return in grant order, one per cycle.
- mem_stall: sampled combinationally. While mem_stall=1, all gnt=0 and mem_en=0 from the next cycle. The return pipeline keeps shifting, so outstanding reads still complete.
- FSM states:
  - IDLE: no req.
  - ISSUE: at least one req and mem_stall=0.
  - STALLED: mem_stall=1 with at least one req.
  - IDLE→ISSUE on any req & ~mem_stall.
  - ISSUE→STALLED on mem_stall.
  - STALLED→ISSUE when mem_stall falls and a req is pending.
  - Any state→IDLE when there is no req.
  - The state is exposed only through behaviour and drives the counters.
- Fairness: with all three requesting continuously, the grant sequence from reset is 1,2,3,1,2,3. A port waits at most 2 grant cycles between its grants.
- Requester rule: the requester may change pK_we/addr/wdata only in the cycle after its gnt, or while req=0.

Optional Feature:
TPM_SCHED_STATS_EN:
- Defined:
  - Adds input stat_clr (1 bit).
  - Adds outputs stat_p1_cnt, stat_p2_cnt, stat_p3_cnt (16 bits each), which count grants per port and saturate at 16'hFFFF.
  - Adds output stat_stall_cnt (16 bits), which counts STALLED cycles and also saturates.
  - stat_clr synchronously zeroes all counters and takes priority over an increment in the same cycle.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Only p2 reads addr 0x005 in cycle T (MEM_LAT=1) → p2_gnt=1 at T, mem_en=1/mem_addr=0x005 at T+1, p2_rvalid=1 with SRAM data at T+3; no other rvalid.
- p1, p2, p3 all request reads continuously from reset for 6 cycles → grants 1,2,3,1,2,3; returns in the same order, one per cycle.
- Order 123, only p3 requests, then p1+p3 request → p3 granted first (order becomes 123→123 after serving 3), then p1, then p3.
- mem_stall=1 for 3 cycles while p1 requests, with one read outstanding → no gnt and mem_en=0 during the stall; the outstanding rvalid still arrives on time; p1 is granted in the first cycle after the stall drops.
- Assert reset_n low one cycle after a read grant → no rvalid ever appears for that read; outputs read as 0; after release, order is 123 and p1 wins a 3-way contest.
- With TPM_SCHED_STATS_EN: 5 grants to p1 → stat_p1_cnt=5; pulse stat_clr in the same cycle as a p1 grant → count=0.
